stopwatch_ctrl: RTL
===================

# stopwatch_ctrl

Button-driven run controller for the stopwatch datapath. Debounces the two raw Nexys-A7 push buttons, turns them into single-cycle press events, and sequences a four-state run/lap/pause FSM. Generates the gated centisecond tick that advances the seconds/minutes counters, a clear pulse for those counters, and a lap-hold flag that freezes the seven-segment display while counting continues. Sits between the board buttons and the existing counter/display logic, replacing its raw `start` level input.

## Interface
- `DB_CYCLES`, 1_000_000: consecutive stable samples a button needs before its debounced level changes (10 ms at 100 MHz).
- `TICK_DIV`, 1_000_000: clk cycles per centisecond tick (100 MHz → 100 Hz); must be ≥ 2.
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `btn_start`  in  1  raw start/stop button, asynchronous, bouncing.
- `btn_lap`  in  1  raw lap/clear button, asynchronous, bouncing.
- `run`  out  1  high while the stopwatch is counting (RUN or LAP).
- `tick_1csec`  out  1  one-cycle pulse per elapsed centisecond; only pulses while `run`.
- `clr`  out  1  one-cycle pulse requesting the counters be zeroed.
- `lap_hold`  out  1  high while the display must show the frozen lap value.
- `state`  out  2  current FSM state: IDLE=00, RUN=01, LAP=10, PAUSE=11.

## Operation
- Each button passes through a 2-FF synchronizer, then a debounce counter:
  - The counter resets to 0 whenever the synchronized input equals the debounced level.
  - When the counter reaches DB_CYCLES−1 with the input still differing, the debounced level flips.
- Press event: a registered one-cycle pulse on the rising edge of the debounced level. Releases generate no event.
- FSM transitions, evaluated on press pulses:
  - IDLE: start → RUN. lap → `clr` pulse, stay in IDLE.
  - RUN: start → PAUSE. lap → LAP.
  - LAP: start → PAUSE, and hold is released. lap → RUN.
  - PAUSE: start → RUN. lap → IDLE with a `clr` pulse.
- Simultaneous start and lap presses in the same cycle: start wins and lap is discarded.
- Outputs are decoded from the state register:
  - `run` = RUN or LAP.
  - `lap_hold` = LAP.
  - `clr` is registered and coincides with the state update.
- Prescaler:
  - Width is $clog2(TICK_DIV).
  - Increments only while `run`.
  - At TICK_DIV−1 it wraps to 0 and registers `tick_1csec`=1 for one cycle.
  - Holds its value in PAUSE, so a partial interval is preserved.
  - Zeroes on `clr` or `reset`.

## Timing
- Reset values (all registers): state IDLE, `run` 0, `tick_1csec` 0, `clr` 0, `lap_hold` 0, debounced levels 0, all counters 0.
- Reset asserted mid-operation returns the block to these values on the next edge, regardless of button state.
- A button held at 1 through reset is seen as a new press only after debounce completes. This counts as a legal press.
- Latency: a button stable from edge N → press pulse at edge N+DB_CYCLES+3 → state, `run`, `lap_hold` and `clr` update at edge N+DB_CYCLES+4.
- First tick after entering RUN from a cleared prescaler: exactly TICK_DIV cycles after `run` rises.
- After that, one tick every TICK_DIV cycles while `run`.
- A tick in flight on the cycle the FSM leaves RUN/LAP is still emitted. No tick starts once `run` is 0.
- `clr` and `tick_1csec` are never high in the same cycle. `clr` occurs only in IDLE or PAUSE.

## Configuration
- `STOPWATCH_LAP_EN` defined: full behaviour as above.
- `STOPWATCH_LAP_EN` undefined:
  - LAP state is unreachable and `lap_hold` is tied 0.
  - A lap press in RUN is ignored.
  - The lap button keeps its clear function in IDLE and PAUSE.
  - Debounce logic for `btn_lap` is still present.

## Test plan
All scenarios use DB_CYCLES=4 and TICK_DIV=10.
1. Reset sequence: hold `reset` 3 cycles with buttons high, then release.
   - During reset: all outputs 0, `state`=00.
   - Exactly one start press, 8 cycles after release: `state`=01.
2. Bounce: toggle `btn_start` every 2 cycles for 20 cycles, then hold it high.
   - Exactly one transition IDLE→RUN, 8 cycles after the final stable edge.
   - No `run` before that.
3. Ticks: keep RUN for 100 cycles.
   - Exactly 10 `tick_1csec` pulses, 10 cycles apart.
   - First pulse 10 cycles after `run` rises.
4. Pause/resume: stop with the prescaler at 6 (PAUSE, `run`=0, no ticks for 50 cycles), then resume.
   - First tick 4 cycles after `run` returns to 1.
5. Lap (macro defined): RUN → lap press gives `state`=10 and `lap_hold`=1, with ticks continuing every 10 cycles.
   - Second lap press: `state`=01, `lap_hold`=0.
   - With the macro undefined, the same stimulus leaves `state`=01 and `lap_hold`=0 throughout.
6. Clear and priority: in PAUSE, press lap → one-cycle `clr`, `state`=00, prescaler 0.
   - From RUN, press start and lap in the same cycle: `state`=11, no LAP entry, no `clr`.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_ctrl
// Purpose  : Button-driven run controller for the stopwatch datapath.
//            Synchronizes and debounces the raw start and lap buttons,
//            turns debounced rising edges into one-cycle press events and
//            sequences the IDLE/RUN/LAP/PAUSE FSM. Produces the gated
//            centisecond tick, the counter clear pulse and the lap-hold flag.
// Ports    : clk        - system clock (single domain)
//            reset      - synchronous, active-high reset
//            btn_start  - raw start/stop button (asynchronous, bouncing)
//            btn_lap    - raw lap/clear button (asynchronous, bouncing)
//            run        - high in RUN or LAP
//            tick_1csec - one-cycle pulse per centisecond while running
//            clr        - one-cycle request to zero the counters
//            lap_hold   - high while the display shows the frozen lap value
//            state      - FSM state: IDLE=00 RUN=01 LAP=10 PAUSE=11
// Config   : STOPWATCH_LAP_EN - defined: LAP state reachable from RUN.
//                               undefined: lap press in RUN is ignored and
//                               lap_hold stays 0; lap still clears.
// Revision : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl #(
    parameter int DB_CYCLES = 1_000_000,
    parameter int TICK_DIV  = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_lap,
    output logic       run,
    output logic       tick_1csec,
    output logic       clr,
    output logic       lap_hold,
    output logic [1:0] state
);

    localparam int c_db_w    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int c_presc_w = $clog2(TICK_DIV);
    localparam logic [c_db_w-1:0]    c_db_last    = c_db_w'(DB_CYCLES - 1);
    localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_LAP   = 2'b10,
        S_PAUSE = 2'b11
    } state_t;

    // Bit 0 = start, bit 1 = lap.
    logic [1:0] w_btn_raw;
    logic [1:0] w_press;

    assign w_btn_raw = {btn_lap, btn_start};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic              r_sync1;
            logic              r_sync2;
            logic              r_db;
            logic              r_db_d;
            logic              r_press;
            logic [c_db_w-1:0] r_db_cnt;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_sync1  <= 1'b0;
                    r_sync2  <= 1'b0;
                    r_db     <= 1'b0;
                    r_db_d   <= 1'b0;
                    r_press  <= 1'b0;
                    r_db_cnt <= '0;
                end else begin
                    r_sync1 <= w_btn_raw[gi];
                    r_sync2 <= r_sync1;
                    // Any sample agreeing with the debounced level restarts
                    // the stability count, so bounces never accumulate.
                    if (r_sync2 == r_db) begin
                        r_db_cnt <= '0;
                    end else if (r_db_cnt == c_db_last) begin
                        r_db     <= r_sync2;
                        r_db_cnt <= '0;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                    r_db_d  <= r_db;
                    r_press <= r_db & ~r_db_d;
                end
            end

            assign w_press[gi] = r_press;
        end
    endgenerate

    state_t                 r_state;
    logic                   r_run;
    logic                   r_clr;
    logic                   r_lap_hold;
    logic                   r_tick;
    logic [c_presc_w-1:0]   r_presc;
    logic                   w_start;
    logic                   w_lap;
    logic                   w_clr_req;

    // Start has priority: a lap press in the same cycle is dropped.
    assign w_start   = w_press[0];
    assign w_lap     = w_press[1] & ~w_press[0];
    // Lap clears only from the stopped states, so it can never coincide
    // with a tick (the prescaler is idle there).
    assign w_clr_req = w_lap & ((r_state == S_IDLE) || (r_state == S_PAUSE));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_run      <= 1'b0;
            r_lap_hold <= 1'b0;
            r_clr      <= 1'b0;
        end else begin
            r_clr <= w_clr_req;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_RUN;
                        r_run   <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_start) begin
                        r_state <= S_PAUSE;
                        r_run   <= 1'b0;
                    end
`ifdef STOPWATCH_LAP_EN
                    else if (w_lap) begin
                        r_state    <= S_LAP;
                        r_lap_hold <= 1'b1;
                    end
`endif
                end
                S_LAP: begin
                    if (w_start) begin
                        r_state    <= S_PAUSE;
                        r_run      <= 1'b0;
                        r_lap_hold <= 1'b0;
                    end else if (w_lap) begin
                        r_state    <= S_RUN;
                        r_lap_hold <= 1'b0;
                    end
                end
                S_PAUSE: begin
                    if (w_start) begin
                        r_state <= S_RUN;
                        r_run   <= 1'b1;
                    end else if (w_lap) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_run      <= 1'b0;
                    r_lap_hold <= 1'b0;
                end
            endcase
        end
    end

    // Prescaler uses the current run register, so a wrap on the edge that
    // leaves RUN/LAP still produces its tick; it then holds in PAUSE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
        end else if (w_clr_req) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
        end else if (r_run) begin
            if (r_presc == c_presc_last) begin
                r_presc <= '0;
                r_tick  <= 1'b1;
            end else begin
                r_presc <= r_presc + 1'b1;
                r_tick  <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    // Without STOPWATCH_LAP_EN the lap-hold register can never be set.
    assign state      = r_state;
    assign run        = r_run;
    assign clr        = r_clr;
    assign lap_hold   = r_lap_hold;
    assign tick_1csec = r_tick;

endmodule
`default_nettype wire
